// File: rtl/ibex_pkg.sv
// ibex_pkg
//   Shared definitions for the performance-counter controller:
//   - CSR address constants for the counter-control register map.
//   - hpm_csr_num(): maps a counter slot index to its CSR number
//     (slot 0 -> mcycle (0), slot 1 -> minstret (2), slot k -> k+1).
//   - hpm_inhibit_mask(): implemented (writable) bits of mcountinhibit
//     for a given number of counter slots.
package ibex_pkg;

  typedef logic [11:0] csr_addr_t;

  localparam csr_addr_t CSR_MCOUNTINHIBIT = 12'h320;
  localparam csr_addr_t CSR_MHPMEVENT3    = 12'h323;
  localparam csr_addr_t CSR_MCYCLE        = 12'hB00;
  localparam csr_addr_t CSR_MCYCLEH       = 12'hB80;
  localparam csr_addr_t CSR_OVF_STATUS    = 12'h7C0;
  localparam csr_addr_t CSR_OVF_EN        = 12'h7C1;

  function automatic int unsigned hpm_csr_num(int unsigned slot);
    if (slot == 0) begin
      return 0;
    end else if (slot == 1) begin
      return 2;
    end
    return slot + 1;
  endfunction

  // Bit n of mcountinhibit gates the counter whose CSR number is n, so the
  // mask has a hole at bit 1 (time) and nothing above the last slot.
  function automatic logic [31:0] hpm_inhibit_mask(int unsigned num_counters);
    logic [31:0] mask;
    mask = '0;
    for (int unsigned s = 0; s < num_counters; s++) begin
      mask = mask | (32'd1 << hpm_csr_num(s));
    end
    return mask;
  endfunction

endpackage

// File: rtl/ibex_hpm_slot_ctrl.sv
// ibex_hpm_slot_ctrl
//   Per-slot control for one performance counter instance.
//   Selects the slot's event, gates it with inhibit and CSR write
//   collisions, detects overflow and holds the sticky overflow status bit.
//
//   Ports:
//     clk_i, rst_i    clock, synchronous active-high reset
//     event_q_i       registered event vector
//     event_sel_i     mhpmevent selector (ignored for slots 0 and 1)
//     inhibit_i       mcountinhibit bit belonging to this slot
//     csr_wr_hit_i    CSR write to either half of this counter this cycle
//     counter_val_i   current 64-bit counter value
//     ovf_clr_i       write-1-to-clear request for the status bit
//     inc_o           increment strobe
//     ovf_o           sticky overflow status bit
module ibex_hpm_slot_ctrl
  import ibex_pkg::*;
#(
  parameter int unsigned SlotIdx   = 0,
  parameter int unsigned NumEvents = 16,
  parameter int unsigned Width     = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NumEvents-1:0] event_q_i,
  input  logic [NumEvents-1:0] event_sel_i,
  input  logic                 inhibit_i,
  input  logic                 csr_wr_hit_i,
  input  logic [63:0]          counter_val_i,
  input  logic                 ovf_clr_i,
  output logic                 inc_o,
  output logic                 ovf_o
);

  logic slot_event;
  logic ovf_set;
  logic ovf_q;

  if (SlotIdx == 0) begin : g_cycle
    // mcycle counts every cycle
    assign slot_event = 1'b1;
  end else if (SlotIdx == 1) begin : g_instret
    assign slot_event = event_q_i[0];
  end else begin : g_hpm
    assign slot_event = |(event_q_i & event_sel_i);
  end

  // A CSR write to the counter takes priority; the increment is dropped.
  assign inc_o = ~rst_i & slot_event & ~inhibit_i & ~csr_wr_hit_i;

  // Overflow only looks at the implemented width of the counter.
  assign ovf_set = inc_o & (&counter_val_i[Width-1:0]);

  // Set has priority over a coincident clear so no overflow is lost.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_q <= 1'b0;
    end else if (ovf_set) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr_i) begin
      ovf_q <= 1'b0;
    end
  end

  assign ovf_o = ovf_q;

  // Fixed slots ignore the selector and upper counter bits.
  logic unused_inputs;
  assign unused_inputs = ^{event_sel_i, event_q_i, counter_val_i};

endmodule

// File: rtl/ibex_hpm_ctrl.sv
// ibex_hpm_ctrl
//   Controller for the bank of 64-bit performance counter instances.
//   Owns mcountinhibit, the mhpmevent selectors and the overflow
//   status/enable pair; registers incoming events, drives per-slot
//   increment and write strobes, serves CSR reads of counter values and
//   raises a level overflow interrupt.
//
//   Ports:
//     clk_i, rst_i      clock, synchronous active-high reset
//     event_i           per-cycle event pulses (bit 0 = instruction retired)
//     csr_we_i          CSR write strobe
//     csr_addr_i        CSR address
//     csr_wdata_i       CSR write data
//     csr_rdata_o       CSR read data, combinational from csr_addr_i
//     counter_val_i     current value of each counter instance
//     counter_inc_o     increment strobe per slot
//     counter_we_o      low-word write strobe per slot
//     counterh_we_o     high-word write strobe per slot
//     counter_wdata_o   shared write data for all slots
//     irq_o             overflow interrupt, level
//
//   NumEvents must not exceed 32 (selectors are written from one CSR word).
module ibex_hpm_ctrl
  import ibex_pkg::*;
#(
  parameter int unsigned NumCounters     = 6,
  parameter int unsigned NumEvents       = 16,
  parameter int unsigned HpmCounterWidth = 40
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NumEvents-1:0]        event_i,
  input  logic                        csr_we_i,
  input  logic [11:0]                 csr_addr_i,
  input  logic [31:0]                 csr_wdata_i,
  output logic [31:0]                 csr_rdata_o,
  input  logic [NumCounters-1:0][63:0] counter_val_i,
  output logic [NumCounters-1:0]      counter_inc_o,
  output logic [NumCounters-1:0]      counter_we_o,
  output logic [NumCounters-1:0]      counterh_we_o,
  output logic [31:0]                 counter_wdata_o,
  output logic                        irq_o
);

  localparam logic [31:0] InhibitMask = hpm_inhibit_mask(NumCounters);

  logic [NumEvents-1:0]   event_q;
  logic [31:0]            inhibit_q;
  logic [NumCounters-1:0] ovf_en_q;
  logic [NumCounters-1:0] ovf_status;
  logic [31:0]            slot_rdata [NumCounters];
  logic [31:0]            rdata;

  logic wr_inhibit;
  logic wr_ovf_status;
  logic wr_ovf_en;

  assign wr_inhibit    = csr_we_i & (csr_addr_i == CSR_MCOUNTINHIBIT);
  assign wr_ovf_status = csr_we_i & (csr_addr_i == CSR_OVF_STATUS);
  assign wr_ovf_en     = csr_we_i & (csr_addr_i == CSR_OVF_EN);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      event_q   <= '0;
      inhibit_q <= '0;
      ovf_en_q  <= '0;
    end else begin
      event_q <= event_i;
      if (wr_inhibit) begin
        inhibit_q <= csr_wdata_i & InhibitMask;
      end
      if (wr_ovf_en) begin
        ovf_en_q <= csr_wdata_i[NumCounters-1:0];
      end
    end
  end

  for (genvar gi = 0; gi < NumCounters; gi++) begin : g_slot
    localparam logic [4:0]  CsrIdx = 5'(hpm_csr_num(gi));
    localparam int unsigned Width  = (gi < 2) ? 64 : HpmCounterWidth;

    logic                 lo_hit;
    logic                 hi_hit;
    logic [NumEvents-1:0] event_sel;
    logic [31:0]          evt_rdata;

    assign lo_hit = (csr_addr_i == (CSR_MCYCLE  + 12'(CsrIdx)));
    assign hi_hit = (csr_addr_i == (CSR_MCYCLEH + 12'(CsrIdx)));

    if (gi >= 2) begin : g_sel
      logic evt_hit;
      assign evt_hit = (csr_addr_i == (CSR_MHPMEVENT3 + 12'(gi - 2)));

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          event_sel <= '0;
        end else if (csr_we_i && evt_hit) begin
          event_sel <= csr_wdata_i[NumEvents-1:0];
        end
      end

      assign evt_rdata = evt_hit ? 32'(event_sel) : '0;
    end else begin : g_fixed
      assign event_sel = '0;
      assign evt_rdata = '0;
    end

    assign counter_we_o[gi]  = ~rst_i & csr_we_i & lo_hit;
    assign counterh_we_o[gi] = ~rst_i & csr_we_i & hi_hit;

    assign slot_rdata[gi] = (lo_hit ? counter_val_i[gi][31:0]  : 32'd0) |
                            (hi_hit ? counter_val_i[gi][63:32] : 32'd0) |
                            evt_rdata;

    ibex_hpm_slot_ctrl #(
      .SlotIdx   (gi),
      .NumEvents (NumEvents),
      .Width     (Width)
    ) u_slot (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .event_q_i     (event_q),
      .event_sel_i   (event_sel),
      .inhibit_i     (inhibit_q[CsrIdx]),
      .csr_wr_hit_i  (csr_we_i & (lo_hit | hi_hit)),
      .counter_val_i (counter_val_i[gi]),
      .ovf_clr_i     (wr_ovf_status & csr_wdata_i[gi]),
      .inc_o         (counter_inc_o[gi]),
      .ovf_o         (ovf_status[gi])
    );
  end

  // At most one address matches, so the sources can simply be OR-ed.
  always_comb begin
    rdata = '0;
    if (csr_addr_i == CSR_MCOUNTINHIBIT) begin
      rdata = inhibit_q;
    end
    if (csr_addr_i == CSR_OVF_STATUS) begin
      rdata = 32'(ovf_status);
    end
    if (csr_addr_i == CSR_OVF_EN) begin
      rdata = 32'(ovf_en_q);
    end
    for (int k = 0; k < NumCounters; k++) begin
      rdata = rdata | slot_rdata[k];
    end
  end

  assign csr_rdata_o     = rst_i ? 32'd0 : rdata;
  assign counter_wdata_o = rst_i ? 32'd0 : csr_wdata_i;
  assign irq_o           = ~rst_i & (|(ovf_status & ovf_en_q));

endmodule

// File: tb/tb_ibex_hpm_ctrl.sv
module tb_ibex_hpm_ctrl;

  logic             clk;
  logic             rst;
  logic [15:0]      ev;
  logic             we;
  logic [11:0]      addr;
  logic [31:0]      wdata;
  logic [31:0]      rdata;
  logic [5:0][63:0] cval;
  logic [5:0]       inc;
  logic [5:0]       cwe;
  logic [5:0]       chwe;
  logic [31:0]      cwd;
  logic             irq;

  int checks = 0;
  int errors = 0;

  ibex_hpm_ctrl #(
    .NumCounters     (6),
    .NumEvents       (16),
    .HpmCounterWidth (40)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .event_i         (ev),
    .csr_we_i        (we),
    .csr_addr_i      (addr),
    .csr_wdata_i     (wdata),
    .csr_rdata_o     (rdata),
    .counter_val_i   (cval),
    .counter_inc_o   (inc),
    .counter_we_o    (cwe),
    .counterh_we_o   (chwe),
    .counter_wdata_o (cwd),
    .irq_o           (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are checked
  // 1 unit later, well away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ev = '1; we = 1'b1; addr = 12'hB00; wdata = 32'hDEAD_BEEF;
    cval = '0; cval[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      checks++;
      if ({inc, cwe, chwe, cwd, rdata, irq} !== 83'd0) begin
        errors++;
        $display("FAIL reset_outputs: cycle %0d inc=%b we=%b weh=%b wdata=%h rdata=%h irq=%b, required all 0", i, inc, cwe, chwe, cwd, rdata, irq);
      end else $display("pass reset_outputs cycle %0d", i);
    end
    step(); rst = 1'b0; ev = '0; we = 1'b0; addr = 12'h000; cval = '0; #1;
    checks++;
    if (inc !== 6'b000001) begin errors++; $display("FAIL release_inc: got %b required %b", inc, 6'b000001); end
    else $display("pass release_inc %b", inc);
    checks++;
    if ({cwe, chwe, irq} !== 13'd0) begin errors++; $display("FAIL release_misc: got we=%b weh=%b irq=%b required 0", cwe, chwe, irq); end
    else $display("pass release_misc");
    addr = 12'h320; #1;
    checks++;
    if (rdata !== 32'd0) begin errors++; $display("FAIL reset_inhibit_rd: got %h required 0", rdata); end
    else $display("pass reset_inhibit_rd");
    addr = 12'h323; #1;
    checks++;
    if (rdata !== 32'd0) begin errors++; $display("FAIL reset_event_rd: got %h required 0", rdata); end
    else $display("pass reset_event_rd");
    addr = 12'h000;
  endtask

  task automatic test_event_select();
    step(); we = 1'b1; addr = 12'h323; wdata = 32'h0000_0004; ev = '0; #1;
    step(); we = 1'b0; ev = 16'h0004; #1;
    checks++;
    if (inc !== 6'b000001) begin errors++; $display("FAIL evsel_same_cycle: got %b required %b", inc, 6'b000001); end
    else $display("pass evsel_same_cycle");
    step(); ev = '0; #1;
    checks++;
    if (inc !== 6'b000101) begin errors++; $display("FAIL evsel_next: got %b required %b", inc, 6'b000101); end
    else $display("pass evsel_next");
    step(); #1;
    checks++;
    if (inc !== 6'b000001) begin errors++; $display("FAIL evsel_one_cycle: got %b required %b", inc, 6'b000001); end
    else $display("pass evsel_one_cycle");
    step(); ev = 16'h0008; #1;
    step(); ev = '0; #1;
    checks++;
    if (inc !== 6'b000001) begin errors++; $display("FAIL evsel_unselected: got %b required %b", inc, 6'b000001); end
    else $display("pass evsel_unselected");
    step(); ev = 16'h0001; #1;
    step(); ev = '0; #1;
    checks++;
    if (inc !== 6'b000011) begin errors++; $display("FAIL evsel_minstret: got %b required %b", inc, 6'b000011); end
    else $display("pass evsel_minstret");
    step(); we = 1'b1; addr = 12'h324; wdata = 32'hFFFF_FFFF; #1;
    step(); we = 1'b0; addr = 12'h323; #1;
    checks++;
    if (rdata !== 32'h0000_0004) begin errors++; $display("FAIL evsel_readback: got %h required %h", rdata, 32'h4); end
    else $display("pass evsel_readback");
    addr = 12'h324; #1;
    checks++;
    if (rdata !== 32'h0000_FFFF) begin errors++; $display("FAIL evsel_mask: got %h required %h", rdata, 32'hFFFF); end
    else $display("pass evsel_mask");
    addr = 12'h000;
  endtask

  task automatic test_write_collision();
    // mhpmevent3 = 0x4, mhpmevent4 = 0xFFFF from here on
    step(); ev = 16'h0004; #1;
    step(); ev = '0; we = 1'b1; addr = 12'hB03; wdata = 32'h0000_1234; #1;
    checks++;
    if (cwe !== 6'b000100 || chwe !== 6'b000000) begin errors++; $display("FAIL coll_we: got we=%b weh=%b required 000100/000000", cwe, chwe); end
    else $display("pass coll_we");
    checks++;
    if (inc !== 6'b001001) begin errors++; $display("FAIL coll_inc: got %b required %b", inc, 6'b001001); end
    else $display("pass coll_inc");
    checks++;
    if (cwd !== 32'h0000_1234) begin errors++; $display("FAIL coll_wdata: got %h required %h", cwd, 32'h1234); end
    else $display("pass coll_wdata");
    step(); we = 1'b0; #1;
    checks++;
    if (inc !== 6'b000001 || cwe !== 6'b000000) begin errors++; $display("FAIL coll_not_deferred: got inc=%b we=%b required 000001/000000", inc, cwe); end
    else $display("pass coll_not_deferred");
    step(); ev = 16'h0004; #1;
    step(); ev = '0; we = 1'b1; addr = 12'hB83; wdata = 32'h0000_5678; #1;
    checks++;
    if (chwe !== 6'b000100 || cwe !== 6'b000000 || inc !== 6'b001001) begin errors++; $display("FAIL coll_high: got weh=%b we=%b inc=%b required 000100/000000/001001", chwe, cwe, inc); end
    else $display("pass coll_high");
    step(); addr = 12'hB00; #1;
    checks++;
    if (inc !== 6'b000000 || cwe !== 6'b000001) begin errors++; $display("FAIL coll_mcycle: got inc=%b we=%b required 000000/000001", inc, cwe); end
    else $display("pass coll_mcycle");
    step(); we = 1'b0; addr = 12'h000; #1;
  endtask

  task automatic test_inhibit();
    step(); ev = 16'h0001; #1;
    step(); we = 1'b1; addr = 12'h320; wdata = 32'h0000_0005; #1;
    checks++;
    if (inc !== 6'b001011) begin errors++; $display("FAIL inhibit_old: got %b required %b", inc, 6'b001011); end
    else $display("pass inhibit_old");
    step(); we = 1'b0; ev = '0; #1;
    checks++;
    if (inc !== 6'b001000) begin errors++; $display("FAIL inhibit_new: got %b required %b", inc, 6'b001000); end
    else $display("pass inhibit_new");
    checks++;
    if (rdata !== 32'h0000_0005) begin errors++; $display("FAIL inhibit_readback: got %h required %h", rdata, 32'h5); end
    else $display("pass inhibit_readback");
    step(); #1;
    checks++;
    if (inc !== 6'b000000) begin errors++; $display("FAIL inhibit_hold: got %b required %b", inc, 6'b000000); end
    else $display("pass inhibit_hold");
    step(); we = 1'b1; wdata = 32'hFFFF_FFFF; #1;
    step(); we = 1'b0; #1;
    checks++;
    if (rdata !== 32'h0000_007D) begin errors++; $display("FAIL inhibit_mask: got %h required %h", rdata, 32'h7D); end
    else $display("pass inhibit_mask");
    step(); we = 1'b1; wdata = 32'd0; #1;
    step(); we = 1'b0; addr = 12'h000; #1;
    checks++;
    if (inc !== 6'b000001) begin errors++; $display("FAIL inhibit_release: got %b required %b", inc, 6'b000001); end
    else $display("pass inhibit_release");
  endtask

  task automatic test_csr_read();
    step(); cval[3] = 64'h1122_3344_5566_7788; cval[1] = 64'hAAAA_0000_BBBB_0001; addr = 12'hB04; #1;
    checks++;
    if (rdata !== 32'h5566_7788) begin errors++; $display("FAIL read_low: got %h required %h", rdata, 32'h5566_7788); end
    else $display("pass read_low");
    addr = 12'hB84; #1;
    checks++;
    if (rdata !== 32'h1122_3344) begin errors++; $display("FAIL read_high: got %h required %h", rdata, 32'h1122_3344); end
    else $display("pass read_high");
    addr = 12'hB02; #1;
    checks++;
    if (rdata !== 32'hBBBB_0001) begin errors++; $display("FAIL read_minstret: got %h required %h", rdata, 32'hBBBB_0001); end
    else $display("pass read_minstret");
    addr = 12'hB01; #1;
    checks++;
    if (rdata !== 32'd0) begin errors++; $display("FAIL read_unmapped_b01: got %h required 0", rdata); end
    else $display("pass read_unmapped_b01");
    addr = 12'h321; #1;
    checks++;
    if (rdata !== 32'd0) begin errors++; $display("FAIL read_unmapped_321: got %h required 0", rdata); end
    else $display("pass read_unmapped_321");
    step(); cval = '0; addr = 12'h000; #1;
  endtask

  task automatic test_overflow();
    step(); we = 1'b1; addr = 12'h7C1; wdata = 32'h0000_0008; ev = 16'h0001; cval[3] = 64'h0000_007F_FFFF_FFFF; #1;
    step(); we = 1'b0; ev = '0; #1;
    checks++;
    if (inc !== 6'b001011) begin errors++; $display("FAIL ovf_inc: got %b required %b", inc, 6'b001011); end
    else $display("pass ovf_inc");
    checks++;
    if (rdata !== 32'h0000_0008) begin errors++; $display("FAIL ovf_en_read: got %h required %h", rdata, 32'h8); end
    else $display("pass ovf_en_read");
    step(); addr = 12'h7C0; ev = 16'h0001; cval[3] = 64'h0000_00FF_FFFF_FFFF; #1;
    checks++;
    if (rdata !== 32'd0 || irq !== 1'b0) begin errors++; $display("FAIL ovf_no_false: got status=%h irq=%b required 0/0", rdata, irq); end
    else $display("pass ovf_no_false");
    step(); ev = '0; #1;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL ovf_irq_latency: got %b required 0", irq); end
    else $display("pass ovf_irq_latency");
    step(); #1;
    checks++;
    if (rdata !== 32'h0000_0008 || irq !== 1'b1) begin errors++; $display("FAIL ovf_set: got status=%h irq=%b required 08/1", rdata, irq); end
    else $display("pass ovf_set");
    // plain clear
    step(); we = 1'b1; wdata = 32'h0000_0008; #1;
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL ovf_clear_cycle: got irq=%b required 1", irq); end
    else $display("pass ovf_clear_cycle");
    step(); we = 1'b0; #1;
    checks++;
    if (rdata !== 32'd0 || irq !== 1'b0) begin errors++; $display("FAIL ovf_clear: got status=%h irq=%b required 0/0", rdata, irq); end
    else $display("pass ovf_clear");
    // clear coinciding with a fresh overflow
    step(); ev = 16'h0001; #1;
    step(); #1;
    step(); ev = '0; we = 1'b1; wdata = 32'h0000_0008; #1;
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL ovf_reset_before_clear: got irq=%b required 1", irq); end
    else $display("pass ovf_reset_before_clear");
    step(); wdata = 32'h0000_0004; #1;
    checks++;
    if (rdata !== 32'h0000_0008 || irq !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got status=%h irq=%b required 08/1", rdata, irq); end
    else $display("pass ovf_set_wins");
    step(); wdata = 32'h0000_0008; #1;
    checks++;
    if (rdata !== 32'h0000_0008) begin errors++; $display("FAIL ovf_w1c_other_bit: got %h required %h", rdata, 32'h8); end
    else $display("pass ovf_w1c_other_bit");
    step(); we = 1'b0; #1;
    checks++;
    if (rdata !== 32'd0 || irq !== 1'b0) begin errors++; $display("FAIL ovf_final_clear: got status=%h irq=%b required 0/0", rdata, irq); end
    else $display("pass ovf_final_clear");
    // mcycle overflows at 64 bits and is not enabled for the interrupt
    step(); cval[3] = '0; cval[0] = 64'hFFFF_FFFF_FFFF_FFFF; #1;
    step(); cval[0] = 64'h0000_00FF_FFFF_FFFF; #1;
    checks++;
    if (rdata !== 32'h0000_0001 || irq !== 1'b0) begin errors++; $display("FAIL ovf_slot0: got status=%h irq=%b required 01/0", rdata, irq); end
    else $display("pass ovf_slot0");
    step(); we = 1'b1; wdata = 32'h0000_0001; #1;
    step(); we = 1'b0; #1;
    checks++;
    if (rdata !== 32'd0) begin errors++; $display("FAIL ovf_slot0_width: got %h required 0", rdata); end
    else $display("pass ovf_slot0_width");
    cval = '0; addr = 12'h000;
  endtask

  initial begin
    rst = 1'b1; ev = '0; we = 1'b0; addr = '0; wdata = '0; cval = '0;
    test_reset();
    test_event_select();
    test_write_collision();
    test_inhibit();
    test_csr_read();
    test_overflow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
